// File: rtl/y86_mem_arbiter.sv
// Two-requester arbiter for one single-port synchronous memory: the CPU has
// priority, a starvation counter guarantees DMA progress, and one read may be in flight.
module y86_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MEM_LAT      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam logic [3:0] LAT4 = 4'(MEM_LAT);
  localparam logic [3:0] LIM4 = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       owner_dma;
  logic [3:0] starve_cnt;

  logic pick_dma, can_gnt, gnt_c, gnt_d, rd_done, rd_gnt;

  // Outputs are gated by rst so everything reads zero in any reset cycle,
  // even when the reset lands in the middle of a read.
  always_comb begin
    pick_dma = dma_req && (!cpu_req || starve_cnt == LIM4);
    can_gnt  = !rst && state == IDLE;
    gnt_d    = can_gnt && pick_dma;
    gnt_c    = can_gnt && cpu_req && !pick_dma;
    rd_gnt   = (gnt_c && !cpu_we) || (gnt_d && !dma_we);
    rd_done  = !rst && state == RD_WAIT && cnt == 4'd1;
  end

  always_comb begin
    cpu_gnt    = gnt_c;
    dma_gnt    = gnt_d;
    mem_addr   = gnt_d ? dma_addr  : (gnt_c ? cpu_addr  : '0);
    mem_wdata  = gnt_d ? dma_wdata : (gnt_c ? cpu_wdata : '0);
    mem_we     = (gnt_c && cpu_we)  || (gnt_d && dma_we);
    mem_re     = rd_gnt;
    cpu_rvalid = rd_done && !owner_dma;
    dma_rvalid = rd_done && owner_dma;
    cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    dma_rdata  = dma_rvalid ? mem_rdata : '0;
    busy       = !rst && state == RD_WAIT;
  end

  // cnt is loaded with MEM_LAT at the grant and reaches 1 on the data cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner_dma  <= 1'b0;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (rd_gnt) begin
          state     <= RD_WAIT;
          cnt       <= LAT4;
          owner_dma <= gnt_d;
        end
        RD_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (!dma_req || gnt_d)
        starve_cnt <= '0;
      else if (gnt_c && starve_cnt < LIM4)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Directed stimulus with a scoreboard: stimulus queues expected grant/rvalid
// events, a negedge monitor pops and compares whenever the DUT presents one.
module tb_y86_mem_arbiter;
  localparam int AW = 32, DW = 32, LAT = 2, LIM = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, mem_re, mem_we, busy;
  logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  y86_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        cg, dg, cv, dv, re, we;
    logic [31:0] addr, wdata, crd, drd;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, errors = 0;
  int  cyc = 0, due = -1;
  logic [31:0] mem [0:255];
  logic [31:0] rd_val = '0;

  // Memory model: returns the addressed word exactly LAT cycles after mem_re,
  // and a junk pattern in every other cycle.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
    if (mem_re) begin
      rd_val = mem[mem_addr[9:2]];
      due    = cyc + LAT;
    end
    cyc = cyc + 1;
  end
  assign mem_rdata = (cyc == due) ? rd_val : 32'hA5A5_A5A5;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic ev_gnt(input int c, input bit is_dma, input bit we, input logic [31:0] a,
                        input logic [31:0] wd);
    ev_t e;
    e = '{c, !is_dma, is_dma, 1'b0, 1'b0, !we, we, a, wd, 32'h0, 32'h0};
    exp_q.push_back(e);
  endtask

  task automatic ev_rv(input int c, input bit is_dma, input logic [31:0] d);
    ev_t e;
    e = '{c, 1'b0, 1'b0, !is_dma, is_dma, 1'b0, 1'b0, 32'h0, 32'h0,
          is_dma ? 32'h0 : d, is_dma ? d : 32'h0};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (cpu_gnt || dma_gnt || cpu_rvalid || dma_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {60'h0, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid}, 64'h0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        chk("gnt_rvalid", {60'h0, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid},
            {60'h0, e.cg, e.dg, e.cv, e.dv});
        chk("strobes", {62'h0, mem_re, mem_we}, {62'h0, e.re, e.we});
        chk("mem_addr_wdata", {mem_addr, mem_wdata}, {e.addr, e.wdata});
        chk("rdata", {cpu_rdata, dma_rdata}, {e.crd, e.drd});
      end
    end else begin
      chk("idle_outputs", {mem_re, mem_we, mem_addr, mem_wdata[29:0]}, 64'h0);
      chk("idle_rdata", {cpu_rdata, dma_rdata}, 64'h0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_busy(input logic exp);
    @(negedge clk);
    chk("busy", {63'h0, busy}, {63'h0, exp});
    #1;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h04] = 32'hDEAD_BEEF;   // 0x10
    mem[8'h11] = 32'h0BAD_F00D;   // 0x44

    // Reset
    step(); step();
    chk_busy(1'b0);
    step(); rst = 0;

    // CPU read 0x10; DMA pulses once while busy; CPU write waits for IDLE
    step(); t = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ev_gnt(t, 0, 0, 32'h10, 32'h0);
    ev_rv(t + LAT, 0, 32'hDEAD_BEEF);
    step(); cpu_req = 0; dma_req = 1; dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h66;
    chk_busy(1'b1);
    step(); dma_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
    chk_busy(1'b1);
    ev_gnt(t + 3, 0, 1, 32'h20, 32'h55);
    step(); chk_busy(1'b0);
    step(); cpu_req = 0;
    step();

    // Both read at once: CPU first, DMA after the read drains
    step(); t = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10; cpu_wdata = 0;
    dma_req = 1; dma_we = 0; dma_addr = 32'h44; dma_wdata = 0;
    ev_gnt(t, 0, 0, 32'h10, 32'h0);
    ev_rv(t + LAT, 0, 32'hDEAD_BEEF);
    ev_gnt(t + LAT + 1, 1, 0, 32'h44, 32'h0);
    ev_rv(t + 2 * LAT + 1, 1, 32'h0BAD_F00D);
    step(); cpu_req = 0;
    step(); step(); step(); dma_req = 0;
    step(); step(); step();

    // Starvation: 4 CPU write grants, then DMA, then CPU resumes
    t = cyc + 1;
    for (int k = 0; k < 7; k++) begin
      int n;
      step();
      n = (k < 4) ? k : k - 1;
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100 + 32'(4 * n); cpu_wdata = 32'(n);
      dma_req = (k <= 4); dma_we = 1; dma_addr = 32'h200; dma_wdata = 32'h77;
      if (k == 4) ev_gnt(t + k, 1, 1, 32'h200, 32'h77);
      else        ev_gnt(t + k, 0, 1, 32'h100 + 32'(4 * n), 32'(n));
    end
    step(); cpu_req = 0; dma_req = 0;
    step();

    // DMA write then CPU read of the same address
    step(); t = cyc;
    dma_req = 1; dma_we = 1; dma_addr = 32'h40; dma_wdata = 32'h1234;
    ev_gnt(t, 1, 1, 32'h40, 32'h1234);
    ev_gnt(t + 1, 0, 0, 32'h40, 32'h0);
    ev_rv(t + 1 + LAT, 0, 32'h1234);
    step(); dma_req = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 32'h40; cpu_wdata = 0;
    step(); cpu_req = 0;
    step(); step(); step();

    // Reset in the middle of a read
    step(); t = cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    ev_gnt(t, 0, 0, 32'h10, 32'h0);
    step(); cpu_req = 0; rst = 1;
    chk_busy(1'b0);
    step(); cpu_req = 1; cpu_we = 1; cpu_addr = 32'h30; cpu_wdata = 32'h99;
    chk_busy(1'b0);
    step(); rst = 0;
    ev_gnt(t + 3, 0, 1, 32'h30, 32'h99);
    step(); cpu_req = 0;
    for (int i = 0; i < 6; i++) step();

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/y86_mem_arbiter.md
Name: y86_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the y86 core's bus (instruction fetch, load, store) and a secondary DMA/debug requester.
- Serialises all accesses with a request/grant handshake, tracks at most one outstanding read, and steers read data back to whichever requester issued the read.
- CPU has fixed priority, bounded by an anti-starvation counter that guarantees DMA progress.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, cycles from read strobe to valid mem_rdata (legal 1..7)
- STARVE_LIMIT, 4, consecutive CPU grants allowed while DMA is waiting (legal 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- cpu_req  in  1  CPU access request (level, held until cpu_gnt)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  one-cycle grant pulse
- cpu_rvalid  out  1  CPU read data valid pulse
- cpu_rdata  out  DW  CPU read data
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata  same as cpu_* for the DMA side
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_rdata  in  DW  memory read data
- busy  out  1  high while a read is outstanding

Behaviour:
- FSM states: IDLE, RD_WAIT. Grants are issued only in IDLE.
- Arbitration in IDLE, combinational on this cycle's requests:
  - only cpu_req high → CPU wins
  - only dma_req high → DMA wins
  - both high → CPU wins, unless starve_cnt == STARVE_LIMIT, in which case DMA wins
- Grant cycle T:
  - winner's gnt = 1
  - mem_addr, mem_wdata = winner's addr, wdata
  - mem_we = winner's we; mem_re = !winner's we
  - at most one gnt high in any cycle
- Write grant: access completes at T; FSM stays IDLE, so back-to-back grants are possible every cycle.
- Read grant: owner register ← winner; down-counter ← MEM_LAT; FSM → RD_WAIT at T+1.
- RD_WAIT:
  - counter decrements each cycle; no strobes, no grants
  - cycle T+MEM_LAT: owner's rvalid = 1 and owner's rdata = mem_rdata (combinational pass-through)
  - FSM → IDLE at T+MEM_LAT+1, which is the earliest next grant
  - requests arriving or held during RD_WAIT wait; they are not dropped
- starve_cnt (4 bits):
  - increments on each CPU grant while dma_req = 1, saturating at STARVE_LIMIT
  - clears on any DMA grant, or in any cycle where dma_req = 0
- Idle outputs: when no grant and no rvalid, mem_addr, mem_wdata, mem_re, mem_we, both gnt, both rvalid, both rdata = 0.
- busy = (state == RD_WAIT).
- Reset (any cycle, including mid-read):
  - state IDLE, counter 0, owner CPU, starve_cnt 0, all outputs 0
  - an abandoned read never produces rvalid
  - first grant is possible in the cycle after rst deasserts
- Requesters must keep addr, we and wdata stable while req is high and gnt has not yet been seen. Deasserting req before gnt withdraws the request.
- Simultaneous rvalid and gnt cannot occur.

Test Plan:
- MEM_LAT=2, CPU read 0x10 at T with mem returning 0xDEADBEEF at T+2 → cpu_gnt@T, mem_re@T, cpu_rvalid@T+2 with cpu_rdata=0xDEADBEEF, busy T+1..T+2, next grant no earlier than T+3.
- cpu_req and dma_req both rise at T, both reads → cpu_gnt@T; dma_gnt@T+MEM_LAT+1; dma_rvalid 2·MEM_LAT+1 cycles after T; CPU rdata never appears on the DMA port.
- STARVE_LIMIT=4, CPU issues continuous writes, dma_req held high → exactly 4 cpu_gnt pulses, then dma_gnt on the 5th grant cycle, then CPU resumes.
- DMA writes 0x1234 to 0x40, then CPU reads 0x40 → mem_we@T with mem_wdata=0x1234; CPU read grant at T+1; cpu_rdata=0x1234 at T+1+MEM_LAT.
- rst asserted at T+1 during a CPU read granted at T → no cpu_rvalid ever; outputs 0 at T+2; a new request after reset is granted the cycle after rst falls.
- dma_req pulsed for 1 cycle while busy and withdrawn → no dma_gnt, and starve_cnt is 0 afterwards.
